// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage sitting between the PC register and decode. Latches the PC,
// issues a one-cycle word read to instruction memory, and presents the
// returned instruction to decode under a valid/ready handshake. pc_stall
// holds the PC register except on the cycle decode accepts an instruction.
// halt_out (sticky) is raised when an accepted instruction is HALT_INSTR;
// bus_err (sticky) is raised when memory fails to answer within TIMEOUT
// WAIT cycles. Both clear only on rst.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_in                    current PC from the PC register
//   halt                     external freeze (resumable)
//   flush                    drop in-flight / held instruction
//   imem_req, imem_addr      read strobe and word address (registered)
//   imem_rvalid, imem_rdata  memory response
//   instr_valid, instr_ready decode handshake
//   instr_out, instr_pc      fetched instruction and its PC (registered)
//   pc_stall                 to PC register, low only on an accept cycle
//   halt_out, bus_err        sticky halt / memory-timeout flags
module instr_fetch_unit #(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter int               TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] HALT_INSTR = 32'h00100073,
  parameter logic [DATA_W-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              halt,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              pc_stall,
  output logic              halt_out,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             discard;

  assign cnt_nxt = cnt + CNT_W'(1);

  // PC advances only when decode takes the instruction and it is not being flushed.
  assign pc_stall = rst | ~(instr_valid & instr_ready & ~flush);

  // Fetch FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      instr_pc    <= '0;
      halt_out    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (halt || halt_out || bus_err) begin
            state <= S_HALTED;
          end else begin
            // imem_addr doubles as the latched PC for the whole transaction.
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          imem_req <= 1'b0;
          cnt      <= '0;
          // A flush here still lets the request go out, but its data is dropped.
          discard  <= flush;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (discard || flush) begin
              state <= S_IDLE;
            end else begin
              instr_out   <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= S_VALID;
            end
          end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            // Timeout applies even to a discarded response.
            bus_err <= 1'b1;
            discard <= 1'b0;
            state   <= S_HALTED;
          end else begin
            cnt <= cnt_nxt;
            if (flush) begin
              discard <= 1'b1;
            end
          end
        end

        S_VALID: begin
          if (flush) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state       <= S_IDLE;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_out == HALT_INSTR) begin
              halt_out <= 1'b1;
              state    <= S_HALTED;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_HALTED: begin
          // Only an external halt is resumable; sticky flags need rst.
          if (!halt && !halt_out && !bus_err) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        halt;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        pc_stall;
  logic        halt_out;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  // Memory model controls
  int          mem_lat  = 1;
  int          mem_cd   = 0;
  logic        mem_mute = 1'b0;
  logic        mem_rv   = 1'b0;
  logic        man_rv   = 1'b0;
  int          req_cnt  = 0;

  assign imem_rvalid = mem_rv | man_rv;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .halt        (halt),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .pc_stall    (pc_stall),
    .halt_out    (halt_out),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  // Count request pulses seen at each rising edge.
  always @(posedge clk) begin
    if (imem_req === 1'b1) req_cnt = req_cnt + 1;
  end

  // Fixed-latency memory: rvalid for one cycle, mem_lat cycles after imem_req.
  always @(posedge clk) begin
    #1;
    mem_rv = 1'b0;
    if (mem_cd > 0) begin
      mem_cd = mem_cd - 1;
      if (mem_cd == 0) mem_rv = 1'b1;
    end
    if (imem_req === 1'b1 && !mem_mute) mem_cd = mem_lat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      bad = bad + 1;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h0; halt = 1'b0; flush = 1'b0;
    instr_ready = 1'b1; imem_rdata = 32'h00500093; mem_lat = 1;

    // ---- Reset state
    tick(); tick();
    chk("rst_req",   imem_req, 1'b0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_out",   instr_out, NOP);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_halt",  halt_out, 1'b0);
    chk("rst_berr",  bus_err, 1'b0);
    chk("rst_stall", pc_stall, 1'b1);

    // ---- Test 1: basic fetch, L=1
    rst = 1'b0;                      // IDLE cycle
    tick();                          // -> REQ
    chk("t1_req",  imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();                          // -> WAIT
    chk("t1_req_pulse", imem_req, 1'b0);
    chk("t1_stall_wait", pc_stall, 1'b1);
    tick();                          // -> VALID (3 cycles after IDLE)
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_out",   instr_out, 32'h00500093);
    chk("t1_ipc",   instr_pc, 32'h0);
    chk("t1_stall_acc", pc_stall, 1'b0);
    // ---- Test 2 setup: next fetch will be held by backpressure
    pc_in = 32'h5; imem_rdata = 32'h00A00113;
    tick();                          // accept -> IDLE
    chk("t1_valid_clr", instr_valid, 1'b0);
    chk("t1_stall_after", pc_stall, 1'b1);
    instr_ready = 1'b0;
    tick();                          // -> REQ
    chk("t2_req",  imem_req, 1'b1);
    chk("t2_addr", imem_addr, 32'h5);
    tick(); tick();                  // WAIT, VALID
    chk("t2_valid", instr_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", instr_valid, 1'b1);
      chk("t2_hold_out",   instr_out, 32'h00A00113);
      chk("t2_hold_pc",    instr_pc, 32'h5);
      chk("t2_hold_stall", pc_stall, 1'b1);
    end
    chk("t2_reqs", req_cnt, 2);
    instr_ready = 1'b1;
    #1;
    chk("t2_stall_acc", pc_stall, 1'b0);

    // ---- Test 3: halt instruction
    pc_in = 32'h9; imem_rdata = HALT;
    tick();                          // accept -> IDLE
    chk("t2_valid_clr", instr_valid, 1'b0);
    tick(); tick(); tick();          // REQ, WAIT, VALID
    chk("t3_valid", instr_valid, 1'b1);
    chk("t3_out",   instr_out, HALT);
    chk("t3_ipc",   instr_pc, 32'h9);
    tick();                          // accept -> HALTED
    chk("t3_halt",  halt_out, 1'b1);
    chk("t3_valid_clr", instr_valid, 1'b0);
    repeat (20) tick();
    chk("t3_reqs",  req_cnt, 3);
    chk("t3_stall", pc_stall, 1'b1);
    chk("t3_halt_sticky", halt_out, 1'b1);

    // ---- Test 4: memory timeout
    rst = 1'b1;
    tick(); tick();
    chk("t4_halt_rst", halt_out, 1'b0);
    rst = 1'b0; mem_mute = 1'b1; pc_in = 32'h20;
    tick();                          // -> REQ
    chk("t4_req",  imem_req, 1'b1);
    chk("t4_addr", imem_addr, 32'h20);
    tick();                          // -> WAIT
    repeat (15) tick();              // 15 WAIT cycles evaluated
    chk("t4_berr_early", bus_err, 1'b0);
    tick();                          // 16th WAIT cycle -> HALTED
    chk("t4_berr", bus_err, 1'b1);
    imem_rdata = 32'h11111111; man_rv = 1'b1;
    tick();
    man_rv = 1'b0;
    tick();
    chk("t4_ign_valid", instr_valid, 1'b0);
    chk("t4_ign_out",   instr_out, NOP);
    chk("t4_berr_hold", bus_err, 1'b1);
    chk("t4_reqs",      req_cnt, 4);

    // ---- Test 5: flush in WAIT, L=3
    rst = 1'b1;
    tick(); tick();
    chk("t5_berr_rst", bus_err, 1'b0);
    rst = 1'b0; mem_mute = 1'b0; mem_lat = 3;
    imem_rdata = 32'hDEADBEEF; pc_in = 32'h40; instr_ready = 1'b0;
    tick();                          // -> REQ
    chk("t5_req",  imem_req, 1'b1);
    chk("t5_addr", imem_addr, 32'h40);
    tick();                          // -> WAIT
    flush = 1'b1;
    tick();                          // discard set
    chk("t5_valid_a", instr_valid, 1'b0);
    flush = 1'b0; pc_in = 32'h44;
    tick();
    chk("t5_valid_b", instr_valid, 1'b0);
    tick();                          // response consumed -> IDLE
    chk("t5_valid_c", instr_valid, 1'b0);
    chk("t5_out_nop", instr_out, NOP);
    imem_rdata = 32'h12345678;
    tick();                          // -> REQ with new PC
    chk("t5_req2",  imem_req, 1'b1);
    chk("t5_addr2", imem_addr, 32'h44);
    tick(); tick(); tick(); tick();  // WAIT x3, -> VALID
    chk("t5_valid", instr_valid, 1'b1);
    chk("t5_out",   instr_out, 32'h12345678);
    chk("t5_ipc",   instr_pc, 32'h44);

    // ---- Test 6: reset while VALID with ready low
    rst = 1'b1; pc_in = 32'h80;
    tick();
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_out",   instr_out, NOP);
    chk("t6_stall", pc_stall, 1'b1);
    rst = 1'b0;
    tick();                          // IDLE -> REQ
    chk("t6_req",  imem_req, 1'b1);
    chk("t6_addr", imem_addr, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
